// File: rtl/mixer_sequencer_pkg.sv
// Shared definitions for the mixer sequencer: FSM encoding, level codes and default widths.
package mixer_sequencer_pkg;

    localparam int unsigned SAMPLE_WIDTH_DEF  = 8;
    localparam int unsigned LEVEL_WIDTH_DEF   = 3;
    localparam int unsigned OVERRUN_WIDTH     = 8;

    localparam logic [2:0] LEVEL_OFF  = 3'b111;
    localparam logic [2:0] LEVEL_FULL = 3'b000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad1 = 2'd1,
        StLoad2 = 2'd2,
        StExec  = 2'd3
    } seq_state_e;

endpackage

// File: rtl/mixer_sequencer_sample_hold.sv
// Zero-order hold for one oscillator, plus the value a frame snapshot taken this cycle should see
// (a valid coincident with the tick bypasses the stale hold value).
module mixer_sequencer_sample_hold
    import mixer_sequencer_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic [SAMPLE_WIDTH-1:0] i_sample,
    input  logic                    i_valid,
    output logic [SAMPLE_WIDTH-1:0] o_snap
);

    logic [SAMPLE_WIDTH-1:0] r_hold;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_hold <= '0;
        end else if (i_valid) begin
            r_hold <= i_sample;
        end
    end

    assign o_snap = i_valid ? i_sample : r_hold;

endmodule

// File: rtl/mixer_sequencer.sv
// Sequences the two-input mixer once per sample tick: load channel 1, load channel 2, execute.
// Levels are latched at the tick; ticks arriving mid-frame are dropped and counted.
module mixer_sequencer
    import mixer_sequencer_pkg::*;
#(
    parameter int unsigned SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int unsigned LEVEL_WIDTH  = LEVEL_WIDTH_DEF
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [SAMPLE_WIDTH-1:0]  i_osc1_sample,
    input  logic                     i_osc1_valid,
    input  logic [SAMPLE_WIDTH-1:0]  i_osc2_sample,
    input  logic                     i_osc2_valid,
    input  logic [LEVEL_WIDTH-1:0]   i_level_1,
    input  logic [LEVEL_WIDTH-1:0]   i_level_2,
    input  logic                     i_sample_tick,
    output logic [SAMPLE_WIDTH-1:0]  o_sample,
    output logic                     o_sample_1_load,
    output logic                     o_sample_2_load,
    output logic [LEVEL_WIDTH-1:0]   o_sample_1_level,
    output logic [LEVEL_WIDTH-1:0]   o_sample_2_level,
    output logic                     o_execute,
    output logic                     o_busy,
    output logic [OVERRUN_WIDTH-1:0] o_overrun_count
);

    seq_state_e r_state;
    seq_state_e w_state_d;

    logic [SAMPLE_WIDTH-1:0]  w_snap1;
    logic [SAMPLE_WIDTH-1:0]  w_snap2;
    logic [SAMPLE_WIDTH-1:0]  r_frame2;
    logic [SAMPLE_WIDTH-1:0]  r_sample;
    logic                     r_load1;
    logic                     r_load2;
    logic                     r_exec;
    logic                     r_busy;
    logic [LEVEL_WIDTH-1:0]   r_level1;
    logic [LEVEL_WIDTH-1:0]   r_level2;
    logic [OVERRUN_WIDTH-1:0] r_overrun;
    logic                     w_start;
    logic                     w_drop;

    mixer_sequencer_sample_hold #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_hold1 (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_sample (i_osc1_sample),
        .i_valid  (i_osc1_valid),
        .o_snap   (w_snap1)
    );

    mixer_sequencer_sample_hold #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_hold2 (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .i_sample (i_osc2_sample),
        .i_valid  (i_osc2_valid),
        .o_snap   (w_snap2)
    );

    assign w_start = i_sample_tick && (r_state == StIdle);
    assign w_drop  = i_sample_tick && (r_state != StIdle);

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:  if (i_sample_tick) w_state_d = StLoad1;
            StLoad1: w_state_d = StLoad2;
            StLoad2: w_state_d = StExec;
            StExec:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // The bus register itself is the channel-1 frame value during LOAD1; only f2 needs its own
    // register, handed to the bus on the LOAD1 -> LOAD2 edge and held through EXEC.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_frame2  <= '0;
            r_sample  <= '0;
            r_load1   <= 1'b0;
            r_load2   <= 1'b0;
            r_exec    <= 1'b0;
            r_busy    <= 1'b0;
            r_level1  <= '1;
            r_level2  <= '1;
            r_overrun <= '0;
        end else begin
            r_state <= w_state_d;
            r_load1 <= (w_state_d == StLoad1);
            r_load2 <= (w_state_d == StLoad2);
            r_exec  <= (w_state_d == StExec);
            r_busy  <= (w_state_d != StIdle);
            if (w_start) begin
                r_sample <= w_snap1;
                r_frame2 <= w_snap2;
                r_level1 <= i_level_1;
                r_level2 <= i_level_2;
            end else if (r_state == StLoad1) begin
                r_sample <= r_frame2;
            end
            if (w_drop && (r_overrun != '1)) begin
                r_overrun <= r_overrun + 1'b1;
            end
        end
    end

    assign o_sample         = r_sample;
    assign o_sample_1_load  = r_load1;
    assign o_sample_2_load  = r_load2;
    assign o_sample_1_level = r_level1;
    assign o_sample_2_level = r_level2;
    assign o_execute        = r_exec;
    assign o_busy           = r_busy;
    assign o_overrun_count  = r_overrun;

endmodule

// File: tb/tb_mixer_sequencer.sv
// Bench for mixer_sequencer: directed test-plan scenarios then random traffic, checked by a
// frame-level reference model feeding a scoreboard queue drained by an output monitor.
module tb_mixer_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       v1 = 1'b0;
    logic       v2 = 1'b0;
    logic [7:0] s1 = '0;
    logic [7:0] s2 = '0;
    logic [2:0] l1 = '0;
    logic [2:0] l2 = '0;

    logic [7:0] o_sample;
    logic       o_load1;
    logic       o_load2;
    logic [2:0] o_level1;
    logic [2:0] o_level2;
    logic       o_exec;
    logic       o_busy;
    logic [7:0] o_ovr;

    always #5 clk = ~clk;

    mixer_sequencer #(
        .SAMPLE_WIDTH (8),
        .LEVEL_WIDTH  (3)
    ) dut (
        .i_clock          (clk),
        .i_reset          (rst),
        .i_osc1_sample    (s1),
        .i_osc1_valid     (v1),
        .i_osc2_sample    (s2),
        .i_osc2_valid     (v2),
        .i_level_1        (l1),
        .i_level_2        (l2),
        .i_sample_tick    (tick),
        .o_sample         (o_sample),
        .o_sample_1_load  (o_load1),
        .o_sample_2_load  (o_load2),
        .o_sample_1_level (o_level1),
        .o_sample_2_level (o_level2),
        .o_execute        (o_exec),
        .o_busy           (o_busy),
        .o_overrun_count  (o_ovr)
    );

    typedef struct packed {
        logic [7:0] f1;
        logic [7:0] f2;
        logic [2:0] l1;
        logic [2:0] l2;
    } frame_t;

    frame_t      exp_q[$];
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    // Reference model: a frame started at edge m_last occupies the three following cycles, so a
    // tick is accepted only when at least four edges have passed since the last accepted one.
    logic [7:0] m_hold1 = '0;
    logic [7:0] m_hold2 = '0;
    int         m_k = 0;
    int         m_last = -100;
    int         m_cnt = 0;
    logic [2:0] m_lvl1 = 3'b111;
    logic [2:0] m_lvl2 = 3'b111;
    bit         m_busy = 1'b0;
    bit         started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        frame_t f;
        m_k++;
        if (rst) begin
            m_hold1 = '0;
            m_hold2 = '0;
            m_last  = -100;
            m_cnt   = 0;
            m_lvl1  = 3'b111;
            m_lvl2  = 3'b111;
            exp_q.delete();
        end else begin
            if (tick) begin
                if (m_k - m_last >= 4) begin
                    f.f1 = v1 ? s1 : m_hold1;
                    f.f2 = v2 ? s2 : m_hold2;
                    f.l1 = l1;
                    f.l2 = l2;
                    m_lvl1 = l1;
                    m_lvl2 = l2;
                    exp_q.push_back(f);
                    m_last = m_k;
                end else if (m_cnt < 255) begin
                    m_cnt++;
                end
            end
            if (v1) m_hold1 = s1;
            if (v2) m_hold2 = s2;
        end
        m_busy = (m_k - m_last) <= 2;
    endtask

    // Inputs are held across the edge; the model runs just after it, strobes clear shortly after.
    task automatic step();
        @(posedge clk);
        #1 model_edge();
        started = 1'b1;
        #1;
        tick = 1'b0;
        v1   = 1'b0;
        v2   = 1'b0;
        rst  = 1'b0;
    endtask

    // Monitor: pops a frame at each channel-1 load and follows it through load2 and execute.
    logic   rst_seen = 1'b1;
    int     mon_stage = 0;
    frame_t mon_cur;

    always @(posedge clk) rst_seen <= rst;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (started) begin
                chk("busy", o_busy, m_busy);
                chk("overrun_count", o_ovr, m_cnt);
                chk("level_1", o_level1, m_lvl1);
                chk("level_2", o_level2, m_lvl2);
                if (rst_seen) begin
                    mon_stage = 0;
                    chk("strobes_in_reset", {o_load1, o_load2, o_exec}, 3'b000);
                end else if (o_load1) begin
                    chk("load1_stage", mon_stage, 0);
                    chk("load1_exclusive", {o_load2, o_exec}, 2'b00);
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL load1_unexpected: got load strobe, expected none (t=%0t)",
                                 $time);
                        mon_stage = 0;
                    end else begin
                        mon_cur = exp_q.pop_front();
                        chk("load1_sample", o_sample, mon_cur.f1);
                        chk("load1_frame_level", {o_level1, o_level2}, {mon_cur.l1, mon_cur.l2});
                        mon_stage = 1;
                    end
                end else if (mon_stage == 1) begin
                    chk("load2_strobes", {o_load1, o_load2, o_exec}, 3'b010);
                    chk("load2_sample", o_sample, mon_cur.f2);
                    mon_stage = 2;
                end else if (mon_stage == 2) begin
                    chk("exec_strobes", {o_load1, o_load2, o_exec}, 3'b001);
                    chk("exec_sample", o_sample, mon_cur.f2);
                    mon_stage = 0;
                end else begin
                    chk("idle_strobes", {o_load1, o_load2, o_exec}, 3'b000);
                end
            end
        end
    end

    initial begin : driver
        rst = 1'b1;
        step();
        rst = 1'b1;
        step();
        chk("reset_level_1", o_level1, 3'b111);
        chk("reset_sample", o_sample, 0);

        // Basic frame, then zero-order hold reload.
        v1 = 1'b1; s1 = 8'd60; v2 = 1'b1; s2 = 8'd80;
        step();
        tick = 1'b1;
        step();
        repeat (5) step();
        tick = 1'b1;
        step();
        repeat (5) step();

        // Mid-frame update lands only in the following frame.
        tick = 1'b1;
        step();
        v1 = 1'b1; s1 = 8'd100;
        step();
        repeat (4) step();
        tick = 1'b1;
        step();
        repeat (5) step();

        // Bypass: valid coincident with the tick.
        tick = 1'b1; v2 = 1'b1; s2 = 8'd33;
        step();
        repeat (5) step();

        // Overrun: ticks at N, N+2, N+3.
        tick = 1'b1;
        step();
        step();
        tick = 1'b1;
        step();
        tick = 1'b1;
        step();
        repeat (4) step();
        chk("overrun_two", o_ovr, 2);

        repeat (420) begin
            tick = 1'b1;
            step();
        end
        repeat (4) step();
        chk("overrun_saturated", o_ovr, 255);

        // Level latch followed by a reset abort at N+2.
        l1 = 3'b000; l2 = 3'b000;
        tick = 1'b1;
        step();
        l1 = 3'b111;
        step();
        rst = 1'b1;
        step();
        repeat (3) step();
        chk("abort_busy", o_busy, 0);
        chk("abort_level_1", o_level1, 3'b111);
        chk("abort_level_2", o_level2, 3'b111);

        repeat (3000) begin
            tick = ($urandom_range(0, 4) == 0);
            v1   = ($urandom_range(0, 2) == 0);
            v2   = ($urandom_range(0, 2) == 0);
            s1   = 8'($urandom);
            s2   = 8'($urandom);
            if ($urandom_range(0, 7) == 0) l1 = 3'($urandom);
            if ($urandom_range(0, 7) == 0) l2 = 3'($urandom);
            rst  = ($urandom_range(0, 299) == 0);
            step();
        end

        repeat (6) step();
        chk("queue_drained", exp_q.size(), 0);
        chk("monitor_idle", mon_stage, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
